// File: rtl/l0_scaler_bank_if.sv
// Readback port of l0_scaler_bank: request/address in, latched count out one cycle later.
// rd_ovf_o exists only when L0_SCALER_OVF_FLAG_EN is defined.
interface l0_scaler_bank_if #(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned AW        = 4
);
    logic                 rd_req_i;
    logic [AW-1:0]        rd_addr_i;
    logic [CNT_WIDTH-1:0] rd_data_o;
    logic                 rd_valid_o;
`ifdef L0_SCALER_OVF_FLAG_EN
    logic                 rd_ovf_o;

    modport master (output rd_req_i, rd_addr_i, input  rd_data_o, rd_valid_o, rd_ovf_o);
    modport slave  (input  rd_req_i, rd_addr_i, output rd_data_o, rd_valid_o, rd_ovf_o);
`else
    modport master (output rd_req_i, rd_addr_i, input  rd_data_o, rd_valid_o);
    modport slave  (input  rd_req_i, rd_addr_i, output rd_data_o, rd_valid_o);
`endif
endinterface

// File: rtl/l0_scaler_bank.sv
// Bank of L0 trigger-rate scalers: per-channel edge counts over a fixed gate, latched into a
// shadow bank at gate end and read back by address. L0_SCALER_OVF_FLAG_EN adds sticky overflow flags.
module l0_scaler_bank #(
    parameter int unsigned NCHAN       = 12,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned GATE_CYCLES = 100000,
    parameter int unsigned AW          = 4
) (
    input  logic             clk100_i,
    input  logic             rst_n_i,
    input  logic [NCHAN-1:0] trig_i,
    input  logic [NCHAN-1:0] enable_i,
    input  logic             gate_clear_i,
    l0_scaler_bank_if.slave  rd_if,
    output logic             update_o
);
    localparam int unsigned GW = $clog2(GATE_CYCLES);

    logic [NCHAN-1:0]                sync1_q, sync2_q, prev_q;
    logic [NCHAN-1:0][CNT_WIDTH-1:0] run_q, run_d;
    logic [NCHAN-1:0][CNT_WIDTH-1:0] shadow_q, shadow_d;
    logic [NCHAN-1:0][CNT_WIDTH-1:0] bump_c;
    logic [NCHAN-1:0]                inc_c, full_c;
    logic [GW-1:0]                   gate_q, gate_d;
    logic                            terminal_c;
    logic                            update_q, update_d;
    logic [CNT_WIDTH-1:0]            rd_sel_c, rd_data_q, rd_data_d;
    logic                            rd_valid_q, rd_valid_d;

    // Two-stage synchroniser followed by the previous-value register for edge detection
    always_ff @(posedge clk100_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= trig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Per-channel saturating increment candidate
    always_comb begin
        inc_c      = sync2_q & ~prev_q & enable_i;
        terminal_c = (gate_q == GW'(GATE_CYCLES - 1));
        full_c     = '0;
        bump_c     = run_q;
        for (int unsigned ch = 0; ch < NCHAN; ch++) begin
            full_c[ch] = &run_q[ch];
            if (inc_c[ch] && !full_c[ch]) begin
                bump_c[ch] = run_q[ch] + CNT_WIDTH'(1);
            end
        end
    end

    // Gate sequencing: clear wins over the terminal latch and discards that cycle's edges
    always_comb begin
        run_d    = bump_c;
        shadow_d = shadow_q;
        gate_d   = gate_q + GW'(1);
        update_d = 1'b0;
        if (gate_clear_i) begin
            run_d  = '0;
            gate_d = '0;
        end else if (terminal_c) begin
            shadow_d = bump_c;
            run_d    = '0;
            gate_d   = '0;
            update_d = 1'b1;
        end
    end

    // Read mux sees the pre-latch shadow; unmapped addresses return 0
    always_comb begin
        rd_sel_c = '0;
        for (int unsigned ch = 0; ch < NCHAN; ch++) begin
            if (rd_if.rd_addr_i == AW'(ch)) begin
                rd_sel_c = shadow_q[ch];
            end
        end
        rd_valid_d = rd_if.rd_req_i;
        rd_data_d  = rd_if.rd_req_i ? rd_sel_c : rd_data_q;
    end

    always_ff @(posedge clk100_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q      <= '0;
            shadow_q   <= '0;
            gate_q     <= '0;
            update_q   <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            run_q      <= run_d;
            shadow_q   <= shadow_d;
            gate_q     <= gate_d;
            update_q   <= update_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign update_o         = update_q;
    assign rd_if.rd_data_o  = rd_data_q;
    assign rd_if.rd_valid_o = rd_valid_q;

`ifdef L0_SCALER_OVF_FLAG_EN
    logic [NCHAN-1:0] ovf_q, ovf_d, sh_ovf_q, sh_ovf_d;
    logic             rd_ovf_q, rd_ovf_d, rd_ovf_sel_c;

    // Sticky flag: set by an increment attempted at full scale, follows the count lifecycle
    always_comb begin
        ovf_d    = ovf_q | (inc_c & full_c);
        sh_ovf_d = sh_ovf_q;
        if (gate_clear_i) begin
            ovf_d = '0;
        end else if (terminal_c) begin
            sh_ovf_d = ovf_q | (inc_c & full_c);
            ovf_d    = '0;
        end
    end

    always_comb begin
        rd_ovf_sel_c = 1'b0;
        for (int unsigned ch = 0; ch < NCHAN; ch++) begin
            if (rd_if.rd_addr_i == AW'(ch)) begin
                rd_ovf_sel_c = sh_ovf_q[ch];
            end
        end
        rd_ovf_d = rd_if.rd_req_i ? rd_ovf_sel_c : rd_ovf_q;
    end

    always_ff @(posedge clk100_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q    <= '0;
            sh_ovf_q <= '0;
            rd_ovf_q <= 1'b0;
        end else begin
            ovf_q    <= ovf_d;
            sh_ovf_q <= sh_ovf_d;
            rd_ovf_q <= rd_ovf_d;
        end
    end

    assign rd_if.rd_ovf_o = rd_ovf_q;
`endif
endmodule
